mem_access_sequencer: RTL

//  Sequences one load/store through the DataPath memory interface on behalf of the ControlUnit.

---
 rtl/mem_access_sequencer_pkg.sv | 45 ++++
 rtl/mem_align_check.sv | 46 ++++
 rtl/mem_access_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_sequencer_pkg.sv
// Shared definitions for the memory access sequencer and the ControlUnit:
// FSM state encoding, access size codes, trap type codes and the field
// layout of RAM_OpCode.
// Optional feature macro used by the sequencer: MEMSEQ_TIMEOUT_EN.
package mem_access_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_STORE_MDR = 3'd2,
    ST_ACCESS    = 3'd3,
    ST_CAPTURE   = 3'd4,
    ST_DONE      = 3'd5,
    ST_TRAP      = 3'd6
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam logic [2:0] TT_NONE         = 3'b000;
  localparam logic [2:0] TT_ILLEGAL_DEF  = 3'b010;
  localparam logic [2:0] TT_MISALIGN_DEF = 3'b011;
  localparam logic [2:0] TT_TIMEOUT_DEF  = 3'b100;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 15;

  // RAM_OpCode = {2'b00, signed_ld, size, is_store}
  localparam int OPC_STORE_BIT  = 0;
  localparam int OPC_SIZE_LSB   = 1;
  localparam int OPC_SIGNED_BIT = 3;

  function automatic logic [5:0] pack_opcode(input logic       is_store,
                                             input logic [1:0] size,
                                             input logic       signed_ld);
    logic [5:0] op;
    op                       = 6'b000000;
    op[OPC_STORE_BIT]        = is_store;
    op[OPC_SIZE_LSB +: 2]    = size;
    op[OPC_SIGNED_BIT]       = signed_ld;
    return op;
  endfunction

endpackage

// File: rtl/mem_align_check.sv
// Combinational size / address alignment check for one memory access.
// Ports:
//   size_i      access size code (byte/half/word/reserved)
//   addr_low_i  low two bits of the effective address
//   ok_o        1 when the access may proceed to memory
//   tt_o        trap type when ok_o=0, else 3'b000
module mem_align_check
  import mem_access_sequencer_pkg::*;
#(
  parameter logic [2:0] TT_MISALIGN = TT_MISALIGN_DEF,
  parameter logic [2:0] TT_ILLEGAL  = TT_ILLEGAL_DEF
) (
  input  logic [1:0] size_i,
  input  logic [1:0] addr_low_i,
  output logic       ok_o,
  output logic [2:0] tt_o
);

  always_comb begin
    ok_o = 1'b1;
    tt_o = TT_NONE;
    unique case (size_i)
      SIZE_RSVD: begin
        ok_o = 1'b0;
        tt_o = TT_ILLEGAL;
      end
      SIZE_HALF: begin
        if (addr_low_i[0]) begin
          ok_o = 1'b0;
          tt_o = TT_MISALIGN;
        end
      end
      SIZE_WORD: begin
        if (addr_low_i != 2'b00) begin
          ok_o = 1'b0;
          tt_o = TT_MISALIGN;
        end
      end
      default: begin
        ok_o = 1'b1;
        tt_o = TT_NONE;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Sequences one load or store through the MAR/MDR/RAM slice of the
// DataPath on behalf of the ControlUnit, waiting on the RAM MFC handshake.
// Misaligned or reserved-size requests raise a trap instead of touching
// memory. All outputs are decoded from registered state (Moore).
// Optional feature: define MEMSEQ_TIMEOUT_EN to abort an ACCESS that sees
// no MFC within TIMEOUT_CYCLES cycles (trap with TT_TIMEOUT).
// Ports:
//   Clk, RESET                      clock, synchronous active-high reset
//   start, is_store, size,
//   signed_ld, addr_low             request, sampled only in IDLE
//   MFC                             memory function complete
//   MAR_Enable, MDR_Enable,
//   MDR_Mux_select, RAM_enable      DataPath/RAM controls
//   RAM_OpCode                      latched {2'b00, signed_ld, size, is_store}
//   busy, done, trap, tt            status; done/trap are one-cycle pulses
//
// state     | meaning
// IDLE      | waiting for start
// CHECK     | alignment check; MAR loaded if access is legal
// STORE_MDR | MDR loaded from register file (stores only)
// ACCESS    | RAM strobe held until MFC
// CAPTURE   | MDR loaded from RAM (loads only)
// DONE      | done pulse
// TRAP      | trap pulse with tt
module mem_access_sequencer
  import mem_access_sequencer_pkg::*;
#(
`ifdef MEMSEQ_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [2:0]  TT_TIMEOUT     = TT_TIMEOUT_DEF,
`endif
  parameter logic [2:0]  TT_MISALIGN    = TT_MISALIGN_DEF,
  parameter logic [2:0]  TT_ILLEGAL     = TT_ILLEGAL_DEF
) (
  input  logic       Clk,
  input  logic       RESET,
  input  logic       start,
  input  logic       is_store,
  input  logic [1:0] size,
  input  logic       signed_ld,
  input  logic [1:0] addr_low,
  input  logic       MFC,
  output logic       MAR_Enable,
  output logic       MDR_Enable,
  output logic       MDR_Mux_select,
  output logic       RAM_enable,
  output logic [5:0] RAM_OpCode,
  output logic       busy,
  output logic       done,
  output logic       trap,
  output logic [2:0] tt
);

  state_e     state_q, state_d;
  logic       is_store_q, is_store_d;
  logic [1:0] size_q, size_d;
  logic       signed_q, signed_d;
  logic [1:0] addr_q, addr_d;
  logic [2:0] tt_q, tt_d;

  logic       chk_ok;
  logic [2:0] chk_tt;

  mem_align_check #(
    .TT_MISALIGN(TT_MISALIGN),
    .TT_ILLEGAL (TT_ILLEGAL)
  ) u_align (
    .size_i    (size_q),
    .addr_low_i(addr_q),
    .ok_o      (chk_ok),
    .tt_o      (chk_tt)
  );

`ifdef MEMSEQ_TIMEOUT_EN
  logic [3:0] cnt_q, cnt_d;
  logic       timed_out;

  // Counter is zero whenever the FSM is outside ACCESS, so it is already
  // clear on ACCESS entry and counts the ACCESS cycles spent so far.
  assign cnt_d     = (state_q == ST_ACCESS) ? cnt_q + 4'd1 : 4'd0;
  assign timed_out = (cnt_q == 4'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk) begin
    if (RESET) cnt_q <= 4'd0;
    else       cnt_q <= cnt_d;
  end
`endif

  always_ff @(posedge Clk) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      is_store_q <= 1'b0;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      addr_q     <= 2'b00;
      tt_q       <= TT_NONE;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      addr_q     <= addr_d;
      tt_q       <= tt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    is_store_d     = is_store_q;
    size_d         = size_q;
    signed_d       = signed_q;
    addr_d         = addr_q;
    tt_d           = tt_q;
    MAR_Enable     = 1'b0;
    MDR_Enable     = 1'b0;
    MDR_Mux_select = 1'b0;
    RAM_enable     = 1'b0;
    done           = 1'b0;
    trap           = 1'b0;
    tt             = TT_NONE;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          is_store_d = is_store;
          size_d     = size;
          signed_d   = signed_ld;
          addr_d     = addr_low;
          state_d    = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!chk_ok) begin
          tt_d    = chk_tt;
          state_d = ST_TRAP;
        end else begin
          MAR_Enable = 1'b1;
          state_d    = is_store_q ? ST_STORE_MDR : ST_ACCESS;
        end
      end
      ST_STORE_MDR: begin
        MDR_Enable = 1'b1;
        state_d    = ST_ACCESS;
      end
      ST_ACCESS: begin
        RAM_enable     = 1'b1;
        MDR_Mux_select = !is_store_q;
        // MFC in the same cycle as the timeout limit still completes.
        if (MFC) begin
          state_d = is_store_q ? ST_DONE : ST_CAPTURE;
        end
`ifdef MEMSEQ_TIMEOUT_EN
        else if (timed_out) begin
          tt_d    = TT_TIMEOUT;
          state_d = ST_TRAP;
        end
`endif
      end
      ST_CAPTURE: begin
        MDR_Enable     = 1'b1;
        MDR_Mux_select = 1'b1;
        RAM_enable     = 1'b1;
        state_d        = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_TRAP: begin
        trap    = 1'b1;
        tt      = tt_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign RAM_OpCode = pack_opcode(is_store_q, size_q, signed_q);

endmodule
